fifo_sync: RTL and testbench
============================

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter DATO_WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter FIFO_LENGTH, default 16, entry count (>=2, any integer, power of two not required).
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_LENGTH-1, almost-full threshold.
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost-empty threshold.
REQ-005 SHALL have parameter OVERWRITE, default 0: 0 drops writes when full, 1 discards the oldest entry.
REQ-006 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: wr  in  1  write request; datin  in  DATO_WIDTH  write data.
REQ-009 SHALL have ports: rd  in  1  read request; clr_err  in  1  synchronous clear of sticky error flags.
REQ-010 SHALL have ports: datout  out  DATO_WIDTH  registered read data.
REQ-011 SHALL have ports: full, empy, dato (non-empty), afull, aempty  out  1 each  status flags.
REQ-012 SHALL have ports: count  out  $clog2(FIFO_LENGTH+1)  current occupancy.
REQ-013 SHALL have ports: ovf, udf  out  1 each  sticky overflow and underflow flags.

Function
REQ-014 SHALL hold the occupancy in a registered counter; count SHALL never exceed FIFO_LENGTH.
REQ-015 SHALL derive flags combinationally from count: empy=(count==0), full=(count==FIFO_LENGTH), dato=(count!=0), afull=(count>=AF_LEVEL), aempty=(count<=AE_LEVEL).
REQ-016 SHALL wrap the write and read pointers from FIFO_LENGTH-1 to 0.
REQ-017 Write-only, not full: store datin at the write pointer, advance the pointer, count+1.
REQ-018 Read-only, not empty: datout <= oldest entry on that edge (1-cycle latency), advance the read pointer, count-1.
REQ-019 Read-only while empty: datout holds, count unchanged, udf set.
REQ-020 Write-only while full with OVERWRITE=0: write dropped, memory and count unchanged, ovf set.
REQ-021 Write-only while full with OVERWRITE=1: datin stored, both pointers advance, count stays FIFO_LENGTH, ovf set.
REQ-022 Simultaneous wr and rd while empty: bypass, datout <= datin, pointers and count unchanged, no flag set.
REQ-023 Simultaneous wr and rd, 0<count<=FIFO_LENGTH (including full): both accepted, datout <= oldest entry, both pointers advance, count unchanged, no flag set.
REQ-024 ovf and udf SHALL stay set until clr_err; if clr_err coincides with a new error, set wins.
REQ-025 datout SHALL hold its value on all cycles with no accepted read or bypass.

Reset
REQ-026 rst low SHALL immediately, without a clock, force count=0, both pointers=0, datout=0, ovf=0, udf=0.
REQ-027 During reset flags SHALL read empy=1, full=0, dato=0, aempty=1, afull=(AF_LEVEL==0).
REQ-028 Memory contents need not be cleared; after reset, stale entries SHALL never be readable.
REQ-029 Reset asserted mid-operation SHALL abandon any in-flight access; the first edge after rst rises SHALL behave as from the empty state.

Verification (DATO_WIDTH=8, FIFO_LENGTH=5, AF_LEVEL=4, AE_LEVEL=1)
REQ-030 Write 0x11..0x55, then read 5 times -> full=1 after 5th write; datout 0x11..0x55 in order, one cycle after each rd; empy=1 at end, no ovf/udf.
REQ-031 OVERWRITE=0, fill with 0x11..0x55, write 0x66, read all -> ovf=1, count stays 5, reads return 0x11..0x55.
REQ-032 OVERWRITE=1, same stimulus -> ovf=1, count stays 5, reads return 0x22..0x66.
REQ-033 Empty, wr+rd with datin=0xA5 -> next cycle datout=0xA5, count=0; then rd alone -> udf=1, datout stays 0xA5; clr_err -> udf=0.
REQ-034 Run 12 interleaved write/read cycles at count=3 (pointer wrap) -> order preserved; afull=1 at count 4, aempty=1 at count<=1.
REQ-035 Pull rst low between clock edges at count=3 -> count=0, empy=1, datout=0 before the next edge; next write/read returns the new data only.

Source files
------------

// File: rtl/fifo_sync.sv
// Synchronous single-clock FIFO with occupancy counter, derived status flags,
// sticky overflow/underflow flags and optional overwrite-oldest behaviour.
module fifo_sync #(
   parameter int DATO_WIDTH  = 8,
   parameter int FIFO_LENGTH = 16,
   parameter int AF_LEVEL    = FIFO_LENGTH - 1,
   parameter int AE_LEVEL    = 1,
   parameter int OVERWRITE   = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wr,
   input  logic [DATO_WIDTH-1:0]                datin,
   input  logic                                 rd,
   input  logic                                 clr_err,
   output logic [DATO_WIDTH-1:0]                datout,
   output logic                                 full,
   output logic                                 empy,
   output logic                                 dato,
   output logic                                 afull,
   output logic                                 aempty,
   output logic [$clog2(FIFO_LENGTH+1)-1:0]     count,
   output logic                                 ovf,
   output logic                                 udf
);

   localparam int PW = $clog2(FIFO_LENGTH);
   localparam int CW = $clog2(FIFO_LENGTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_LENGTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_LENGTH);

   logic [DATO_WIDTH-1:0] mem_q [FIFO_LENGTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATO_WIDTH-1:0] datout_q, datout_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  mem_we;
   logic                  set_ovf, set_udf;
   logic                  is_empty, is_full;
   logic [DATO_WIDTH-1:0] rd_data;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);
   assign rd_data  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      datout_d = datout_q;
      mem_we   = 1'b0;
      set_ovf  = 1'b0;
      set_udf  = 1'b0;

      if (wr && rd) begin
         if (is_empty) begin
            // Bypass: nothing stored, the write goes straight to the output.
            datout_d = datin;
         end else begin
            datout_d = rd_data;
            mem_we   = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
      end else if (wr) begin
         if (!is_full) begin
            mem_we   = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d  = count_q + CW'(1);
         end else begin
            set_ovf = 1'b1;
            if (OVERWRITE != 0) begin
               // Full means wr_ptr == rd_ptr: the new word replaces the oldest.
               mem_we   = 1'b1;
               wr_ptr_d = ptr_inc(wr_ptr_q);
               rd_ptr_d = ptr_inc(rd_ptr_q);
            end
         end
      end else if (rd) begin
         if (!is_empty) begin
            datout_d = rd_data;
            rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d  = count_q - CW'(1);
         end else begin
            set_udf = 1'b1;
         end
      end

      ovf_d = (ovf_q & ~clr_err) | set_ovf;
      udf_d = (udf_q & ~clr_err) | set_udf;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         datout_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         datout_q <= datout_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is not reset; count gating keeps stale words unreachable.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= datin;
      end
   end

   assign datout = datout_q;
   assign count  = count_q;
   assign ovf    = ovf_q;
   assign udf    = udf_q;
   assign empy   = is_empty;
   assign full   = is_full;
   assign dato   = !is_empty;
   assign afull  = (int'(count_q) >= AF_LEVEL);
   assign aempty = (int'(count_q) <= AE_LEVEL);

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: two instances (drop-on-full and overwrite-oldest) driven
// identically and compared every cycle against queue-based reference models.
module tb_fifo_sync;
   localparam int W = 8;
   localparam int L = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
   logic [W-1:0] datin = '0;

   logic [W-1:0] dout0, dout1;
   logic         full0, empy0, dato0, afull0, aempty0, ovf0, udf0;
   logic         full1, empy1, dato1, afull1, aempty1, ovf1, udf1;
   logic [2:0]   count0, count1;

   always #5 clk = ~clk;

   fifo_sync #(.DATO_WIDTH(W), .FIFO_LENGTH(L), .AF_LEVEL(4), .AE_LEVEL(1), .OVERWRITE(0)) u_ow0 (
      .clk(clk), .rst(rst), .wr(wr), .datin(datin), .rd(rd), .clr_err(clr_err),
      .datout(dout0), .full(full0), .empy(empy0), .dato(dato0), .afull(afull0),
      .aempty(aempty0), .count(count0), .ovf(ovf0), .udf(udf0));

   fifo_sync #(.DATO_WIDTH(W), .FIFO_LENGTH(L), .AF_LEVEL(4), .AE_LEVEL(1), .OVERWRITE(1)) u_ow1 (
      .clk(clk), .rst(rst), .wr(wr), .datin(datin), .rd(rd), .clr_err(clr_err),
      .datout(dout1), .full(full1), .empy(empy1), .dato(dato1), .afull(afull1),
      .aempty(aempty1), .count(count1), .ovf(ovf1), .udf(udf1));

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference models: contents as queues, oldest at the front.
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   logic [W-1:0] md0 = '0, md1 = '0;
   bit mo0 = 0, mu0 = 0, mo1 = 0, mu1 = 0;
   bit eo, eu;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q0.delete(); q1.delete();
         md0 = '0; md1 = '0;
         mo0 = 0; mu0 = 0; mo1 = 0; mu1 = 0;
      end else begin
         eo = 0; eu = 0;
         if (wr && rd) begin
            if (q0.size() == 0) md0 = datin;
            else begin md0 = q0.pop_front(); q0.push_back(datin); end
         end else if (wr) begin
            if (q0.size() < L) q0.push_back(datin);
            else eo = 1;
         end else if (rd) begin
            if (q0.size() > 0) md0 = q0.pop_front();
            else eu = 1;
         end
         mo0 = (mo0 && !clr_err) || eo;
         mu0 = (mu0 && !clr_err) || eu;

         eo = 0; eu = 0;
         if (wr && rd) begin
            if (q1.size() == 0) md1 = datin;
            else begin md1 = q1.pop_front(); q1.push_back(datin); end
         end else if (wr) begin
            if (q1.size() < L) q1.push_back(datin);
            else begin eo = 1; void'(q1.pop_front()); q1.push_back(datin); end
         end else if (rd) begin
            if (q1.size() > 0) md1 = q1.pop_front();
            else eu = 1;
         end
         mo1 = (mo1 && !clr_err) || eo;
         mu1 = (mu1 && !clr_err) || eu;
      end
   end

   task automatic cmp(input string t, input logic [W-1:0] d, input logic [2:0] c,
                      input logic f, input logic e, input logic dt, input logic af,
                      input logic ae, input logic o, input logic u,
                      input int n, input logic [W-1:0] md, input bit mo, input bit mu);
      chk({t, ".datout"}, 32'(d), 32'(md));
      chk({t, ".count"},  32'(c), 32'(n));
      chk({t, ".full"},   32'(f), 32'(n == L));
      chk({t, ".empy"},   32'(e), 32'(n == 0));
      chk({t, ".dato"},   32'(dt), 32'(n != 0));
      chk({t, ".afull"},  32'(af), 32'(n >= 4));
      chk({t, ".aempty"}, 32'(ae), 32'(n <= 1));
      chk({t, ".ovf"},    32'(o), 32'(mo));
      chk({t, ".udf"},    32'(u), 32'(mu));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("ow0", dout0, count0, full0, empy0, dato0, afull0, aempty0, ovf0, udf0,
             q0.size(), md0, mo0, mu0);
         cmp("ow1", dout1, count1, full1, empy1, dato1, afull1, aempty1, ovf1, udf1,
             q1.size(), md1, mo1, mu1);
      end
   end

   task automatic cyc(input bit w, input bit r, input logic [W-1:0] d, input bit c);
      wr = w; rd = r; datin = d; clr_err = c;
      @(posedge clk);
      @(negedge clk);
      wr = 0; rd = 0; clr_err = 0;
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
   endtask

   logic [W-1:0] v;

   initial begin
      #1 rst = 1'b0;
      #1;
      chk("rst.count", 32'(count0), 0);
      chk("rst.empy", 32'(empy0), 1);
      chk("rst.full", 32'(full0), 0);
      chk("rst.dato", 32'(dato0), 0);
      chk("rst.aempty", 32'(aempty0), 1);
      chk("rst.afull", 32'(afull0), 0);
      chk("rst.datout", 32'(dout0), 0);
      chk("rst.ovf_udf", 32'({ovf0, udf0, ovf1, udf1}), 0);
      chk_en = 1;
      @(negedge clk);
      #1 rst = 1'b1;

      // Fill then drain in order
      for (int i = 1; i <= 5; i++) begin v = 8'(17 * i); cyc(1, 0, v, 0); end
      chk("fill.full", 32'(full0), 1);
      chk("fill.count", 32'(count0), 5);
      for (int i = 1; i <= 5; i++) begin
         cyc(0, 1, '0, 0);
         chk("drain.dout0", 32'(dout0), 32'(17 * i));
         chk("drain.dout1", 32'(dout1), 32'(17 * i));
      end
      chk("drain.empy", 32'(empy0), 1);
      chk("drain.noerr", 32'({ovf0, udf0}), 0);

      // Write on full: drop vs overwrite-oldest
      do_reset();
      for (int i = 1; i <= 5; i++) begin v = 8'(17 * i); cyc(1, 0, v, 0); end
      cyc(1, 0, 8'h66, 0);
      chk("ovf.ow0", 32'(ovf0), 1);
      chk("ovf.ow1", 32'(ovf1), 1);
      chk("ovf.count0", 32'(count0), 5);
      chk("ovf.count1", 32'(count1), 5);
      for (int i = 1; i <= 5; i++) begin
         cyc(0, 1, '0, 0);
         chk("ovf.rd0", 32'(dout0), 32'(17 * i));
         chk("ovf.rd1", 32'(dout1), 32'(17 * (i + 1)));
      end

      // Bypass on empty, then underflow and clear
      do_reset();
      cyc(1, 1, 8'hA5, 0);
      chk("byp.dout", 32'(dout0), 32'hA5);
      chk("byp.count", 32'(count0), 0);
      chk("byp.noerr", 32'({ovf0, udf0}), 0);
      cyc(0, 1, '0, 0);
      chk("udf.set", 32'(udf0), 1);
      chk("udf.hold", 32'(dout0), 32'hA5);
      cyc(0, 0, '0, 1);
      chk("udf.clr", 32'(udf0), 0);

      // Interleaved traffic around count 3-4 across pointer wrap
      do_reset();
      for (int i = 1; i <= 3; i++) cyc(1, 0, 8'(i), 0);
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) begin
            cyc(1, 0, 8'(8'h80 + i), 0);
            chk("ilv.afull", 32'(afull0), 1);
         end else begin
            cyc(0, 1, '0, 0);
         end
      end
      cyc(0, 1, '0, 0);
      cyc(0, 1, '0, 0);
      chk("ilv.aempty", 32'(aempty0), 1);
      chk("ilv.count1", 32'(count0), 1);

      // Reset between edges with data in flight
      do_reset();
      for (int i = 1; i <= 3; i++) cyc(1, 0, 8'(8'h30 + i), 0);
      #2 rst = 1'b0;
      #1;
      chk("mid.count", 32'(count0), 0);
      chk("mid.empy", 32'(empy0), 1);
      chk("mid.datout", 32'(dout0), 0);
      chk("mid.count1", 32'(count1), 0);
      @(negedge clk);
      #1 rst = 1'b1;
      cyc(1, 0, 8'h77, 0);
      cyc(0, 1, '0, 0);
      chk("mid.new", 32'(dout0), 32'h77);
      chk("mid.empty_after", 32'(empy0), 1);

      // Randomised traffic with shifting bias
      for (int i = 0; i < 4000; i++) begin
         int pw, pr;
         pw = (i < 2000) ? 65 : 40;
         pr = (i < 2000) ? 40 : 65;
         if ($urandom_range(0, 499) == 0) do_reset();
         cyc(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
             8'($urandom), ($urandom_range(0, 19) == 0));
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
